mm_tile_instruction_sequencer: RTL
==================================

// Module: mm_tile_instruction_sequencer
// PURPOSE
//  Upstream controller for the A-side and B-side memory buffers in the sum-stationary matmul datapath.
//  Accepts one matmul command (A/B base addresses, K length, row-tile and column-tile counts).
//  Walks the tiles and issues buffer instructions (address, length, repeats) on two independent valid/ready channels.
//  Pulses done once the last instruction is accepted; it does not wait for the data stream to drain.
// PARAMETERS
//  B_N                   2     log2 of PE vector width
//  N                     1<<B_N  PE vector width; also values per K step in one tile
//  MEMORY_ADDRESS_BITS   64    memory address width
//  COUNTER_BITS          13    K length width, i.e. $clog2(MAX_MATRIX_LENGTH+1) with MAX_MATRIX_LENGTH=4096
//  REPEATS_COUNTER_BITS  11    repeats field width; also the column-tile count width
//  TILE_COUNTER_BITS     11    row-tile count width
// PORTS
//  clk              in   1                     clock
//  reset            in   1                     synchronous, active-high reset
//  cmd_valid        in   1                     command valid
//  cmd_ready        out  1                     command ready (IDLE only)
//  cmd_a_base       in   MEMORY_ADDRESS_BITS   A tile 0 start address
//  cmd_b_base       in   MEMORY_ADDRESS_BITS   B tile 0 start address
//  cmd_k_len        in   COUNTER_BITS          shared K dimension
//  cmd_m_tiles      in   TILE_COUNTER_BITS     number of A row tiles
//  cmd_p_tiles      in   REPEATS_COUNTER_BITS  number of B column tiles
//  a_instr_valid    out  1                     A-buffer instruction valid
//  a_instr_ready    in   1                     A-buffer instruction ready
//  a_instr_address  out  MEMORY_ADDRESS_BITS   A tile address
//  a_instr_length   out  COUNTER_BITS          = K
//  a_instr_repeats  out  REPEATS_COUNTER_BITS  = p_tiles
//  b_instr_valid    out  1                     B-buffer instruction valid
//  b_instr_ready    in   1                     B-buffer instruction ready
//  b_instr_address  out  MEMORY_ADDRESS_BITS   B tile address
//  b_instr_length   out  COUNTER_BITS          = K
//  b_instr_repeats  out  REPEATS_COUNTER_BITS  constant 1
//  done             out  1                     1-cycle pulse after the final B handshake
//  cmd_error        out  1                     1-cycle pulse when a command is rejected
// BEHAVIOUR
//  Reset: synchronous, active-high, clk. Takes priority over all handshakes, including mid-operation.
//   -> state IDLE; all valids, done, cmd_error = 0; counters and addresses = 0.
//   -> cmd_ready = 0 while reset is high. Instructions in flight are abandoned, not completed.
//  Handshake: a transfer occurs on a rising edge with valid && ready.
//   -> Every valid is registered. Once high, it holds with stable payload until its handshake.
//   -> Outputs never depend combinationally on an input ready.
//  Command capture (IDLE, cmd_valid): register all fields; stride = k_len << B_N, zero-extended.
//   -> If k_len==0, m_tiles==0 or p_tiles==0: pulse cmd_error next cycle, stay IDLE, no instruction issued.
//   -> Otherwise: a_addr = a_base, b_addr = b_base, i = 0, j = 0, go to ISSUE_A.
//  States:
//   IDLE: cmd_ready = 1.
//   ISSUE_A: a_instr_valid = 1 with {a_addr, k_len, p_tiles}.
//    -> On handshake: a_addr += stride, go to ISSUE_B.
//   ISSUE_B: b_instr_valid = 1 with {b_addr, k_len, 1}.
//    -> On handshake with j < p_tiles-1: j++, b_addr += stride, stay (valid held, next cycle new payload).
//    -> On handshake with j == p_tiles-1 and i < m_tiles-1: i++, j = 0, b_addr = b_base, go to ISSUE_A.
//    -> On handshake with j == p_tiles-1 and i == m_tiles-1: go to DONE.
//   DONE: done = 1 for exactly one cycle, then IDLE. cmd_ready rises the following cycle.
//  Issue pattern:
//   -> Per row tile: 1 A instruction (repeats = p_tiles), then p_tiles B instructions (repeats = 1).
//   -> Total: m_tiles A instructions and m_tiles*p_tiles B instructions.
//   -> a_instr_valid and b_instr_valid are never high in the same cycle.
//  Throughput: ISSUE_A to ISSUE_B costs 1 cycle; back-to-back B handshakes run every cycle when ready is held high.
//  Arithmetic:
//   -> Address adds wrap modulo 2^MEMORY_ADDRESS_BITS; no overflow flag.
//   -> k_len<<B_N is computed at COUNTER_BITS+B_N width before extension.
//  Inputs: cmd_* are ignored outside IDLE. A ready asserted without the matching valid has no effect.
// TESTING
//  1. base A=0x100, B=0x800, K=8, m=2, p=3, readies tied 1.
//     -> A@0x100 rep3; B@0x800, 0x820, 0x840; A@0x120 rep3; B@0x800, 0x820, 0x840; done 1 cycle; 8 handshakes total.
//  2. Same command with random ready backpressure (0-5 cycle stalls).
//     -> Identical instruction sequence; payload stable while valid and not ready; no dropped or duplicated instructions.
//  3. k_len=0, then m=0, then p=0.
//     -> cmd_error pulses each time; no valid ever asserted; cmd_ready returns to 1.
//  4. A base 0xFFFF_FFFF_FFFF_FFF0, K=4, m=2, p=1.
//     -> second A address = 0x0000_0000_0000_0000 (wrap).
//  5. Reset asserted during ISSUE_B, second tile.
//     -> next cycle all valids 0, done 0, cmd_ready 1 after release; a new command then starts from tile 0.
//  6. m=1, p=1, K=4096.
//     -> one A (length 4096, rep 1) and one B; done pulses; cmd_valid held high during the run is not re-accepted until IDLE.

Source files
------------

// File: rtl/mm_tile_instruction_sequencer.sv
// Tile walker for the sum-stationary matmul: turns one command into a stream of
// A-buffer and B-buffer instructions on two independent valid/ready channels.
module mm_tile_instruction_sequencer #(
  parameter int B_N                  = 2,
  parameter int N                    = 1 << B_N,
  parameter int MEMORY_ADDRESS_BITS  = 64,
  parameter int COUNTER_BITS         = 13,
  parameter int REPEATS_COUNTER_BITS = 11,
  parameter int TILE_COUNTER_BITS    = 11
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [MEMORY_ADDRESS_BITS-1:0]  cmd_a_base,
  input  logic [MEMORY_ADDRESS_BITS-1:0]  cmd_b_base,
  input  logic [COUNTER_BITS-1:0]         cmd_k_len,
  input  logic [TILE_COUNTER_BITS-1:0]    cmd_m_tiles,
  input  logic [REPEATS_COUNTER_BITS-1:0] cmd_p_tiles,
  output logic                            a_instr_valid,
  input  logic                            a_instr_ready,
  output logic [MEMORY_ADDRESS_BITS-1:0]  a_instr_address,
  output logic [COUNTER_BITS-1:0]         a_instr_length,
  output logic [REPEATS_COUNTER_BITS-1:0] a_instr_repeats,
  output logic                            b_instr_valid,
  input  logic                            b_instr_ready,
  output logic [MEMORY_ADDRESS_BITS-1:0]  b_instr_address,
  output logic [COUNTER_BITS-1:0]         b_instr_length,
  output logic [REPEATS_COUNTER_BITS-1:0] b_instr_repeats,
  output logic                            done,
  output logic                            cmd_error
);

  localparam int SW = COUNTER_BITS + B_N;
  localparam logic [REPEATS_COUNTER_BITS-1:0] REP_ONE  = REPEATS_COUNTER_BITS'(1);
  localparam logic [TILE_COUNTER_BITS-1:0]    TILE_ONE = TILE_COUNTER_BITS'(1);

  typedef enum logic [1:0] {IDLE, ISSUE_A, ISSUE_B, DONE_S} state_t;

  state_t                          state, state_next;
  logic [MEMORY_ADDRESS_BITS-1:0]  a_addr, b_addr, b_base_r, stride_r;
  logic [COUNTER_BITS-1:0]         k_len_r;
  logic [TILE_COUNTER_BITS-1:0]    m_tiles_r, i_cnt;
  logic [REPEATS_COUNTER_BITS-1:0] p_tiles_r, j_cnt;
  logic                            err_r;
  logic                            cmd_ok, a_hs, b_hs, last_j, last_i;
  logic [SW-1:0]                   stride_narrow;

  assign cmd_ok        = (cmd_k_len != '0) && (cmd_m_tiles != '0) && (cmd_p_tiles != '0);
  assign a_hs          = (state == ISSUE_A) && a_instr_ready;
  assign b_hs          = (state == ISSUE_B) && b_instr_ready;
  assign last_j        = (j_cnt == p_tiles_r - REP_ONE);
  assign last_i        = (i_cnt == m_tiles_r - TILE_ONE);
  // Stride is formed at full K+B_N width so a K of MAX_MATRIX_LENGTH does not truncate.
  assign stride_narrow = SW'(cmd_k_len) << B_N;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_valid && cmd_ok) state_next = ISSUE_A;
      ISSUE_A: if (a_instr_ready) state_next = ISSUE_B;
      ISSUE_B: if (b_instr_ready && last_j) state_next = last_i ? DONE_S : ISSUE_A;
      DONE_S:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready     = (state == IDLE) && !reset;
    a_instr_valid = (state == ISSUE_A);
    b_instr_valid = (state == ISSUE_B);
    done          = (state == DONE_S);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_addr    <= '0;
      b_addr    <= '0;
      b_base_r  <= '0;
      stride_r  <= '0;
      k_len_r   <= '0;
      m_tiles_r <= '0;
      p_tiles_r <= '0;
      i_cnt     <= '0;
      j_cnt     <= '0;
      err_r     <= 1'b0;
    end else begin
      err_r <= (state == IDLE) && cmd_valid && !cmd_ok;
      if (state == IDLE && cmd_valid) begin
        a_addr    <= cmd_a_base;
        b_addr    <= cmd_b_base;
        b_base_r  <= cmd_b_base;
        stride_r  <= MEMORY_ADDRESS_BITS'(stride_narrow);
        k_len_r   <= cmd_k_len;
        m_tiles_r <= cmd_m_tiles;
        p_tiles_r <= cmd_p_tiles;
        i_cnt     <= '0;
        j_cnt     <= '0;
      end
      if (a_hs) a_addr <= a_addr + stride_r;
      if (b_hs) begin
        if (!last_j) begin
          j_cnt  <= j_cnt + REP_ONE;
          b_addr <= b_addr + stride_r;
        end else begin
          j_cnt  <= '0;
          b_addr <= b_base_r;
          if (!last_i) i_cnt <= i_cnt + TILE_ONE;
        end
      end
    end
  end

  assign a_instr_address = a_addr;
  assign a_instr_length  = k_len_r;
  assign a_instr_repeats = p_tiles_r;
  assign b_instr_address = b_addr;
  assign b_instr_length  = k_len_r;
  assign b_instr_repeats = REP_ONE;
  assign cmd_error       = err_r;

endmodule
